// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: program load, run control and instruction stream.
// Branch ports exist only when IFU_BRANCH_EN is defined.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              load_en_in;
  logic [ADDR_W-1:0] load_addr_in;
  logic [31:0]       load_data_in;
  logic [ADDR_W:0]   program_length_in;
  logic              start_in;
  logic              instr_ready_in;
  logic [31:0]       current_instruction;
  logic              instr_valid_out;
  logic [ADDR_W-1:0] pc_out;
  logic              busy_out;
  logic              done_out;
`ifdef IFU_BRANCH_EN
  logic              branch_en_in;
  logic [ADDR_W-1:0] branch_target_in;

  modport master (
    input  load_en_in, load_addr_in, load_data_in,
    input  program_length_in, start_in, instr_ready_in,
    input  branch_en_in, branch_target_in,
    output current_instruction, instr_valid_out, pc_out,
    output busy_out, done_out
  );

  modport slave (
    output load_en_in, load_addr_in, load_data_in,
    output program_length_in, start_in, instr_ready_in,
    output branch_en_in, branch_target_in,
    input  current_instruction, instr_valid_out, pc_out,
    input  busy_out, done_out
  );
`else
  modport master (
    input  load_en_in, load_addr_in, load_data_in,
    input  program_length_in, start_in, instr_ready_in,
    output current_instruction, instr_valid_out, pc_out,
    output busy_out, done_out
  );

  modport slave (
    output load_en_in, load_addr_in, load_data_in,
    output program_length_in, start_in, instr_ready_in,
    input  current_instruction, instr_valid_out, pc_out,
    input  busy_out, done_out
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable sync-read ROM, valid/ready issue, skid reg.
// Optional macro IFU_BRANCH_EN adds branch_en_in / branch_target_in.
module instruction_fetch_unit #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic                      clock_in,
  input logic                      reset_n_in,
  instruction_fetch_unit_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W:0]   fa;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clip;
  logic [ADDR_W:0]   br_addr;

  logic              rd_pending;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] rd_pc;

  logic              out_valid;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_pc;

  logic              skid_valid;
  logic [31:0]       skid_data;
  logic [ADDR_W-1:0] skid_pc;

  logic              run;
  logic              accept;
  logic              rd_en;
  logic              last;
  logic              br;
  logic [1:0]        cnt;

`ifdef IFU_BRANCH_EN
  assign br      = run & bus.branch_en_in;
  assign br_addr = {1'b0, bus.branch_target_in};
`else
  assign br      = 1'b0;
  assign br_addr = '0;
`endif

  assign run    = (state == RUN);
  assign accept = out_valid & bus.instr_ready_in;
  assign cnt    = {1'b0, out_valid} + {1'b0, skid_valid}
                + {1'b0, rd_pending};

  // A read may issue only if its word will have a slot (out or skid)
  assign rd_en = run & ~br & (fa < len_q)
               & ((cnt - {1'b0, accept}) < 2'd2);

  // Last word leaves with nothing behind it and nothing left to fetch
  assign last = run & ~br & accept & (fa >= len_q)
              & (cnt == 2'd1);

  assign len_clip = (bus.program_length_in > DEPTH_W)
                  ? DEPTH_W : bus.program_length_in;

  // Control FSM and fetch address
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
      fa    <= '0;
      len_q <= '0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (bus.start_in) begin
            len_q <= len_clip;
            fa    <= '0;
            state <= (len_clip == '0) ? HALT : RUN;
          end
        end
        RUN: begin
          if (br) begin
            if (br_addr >= len_q) state <= HALT;
            else fa <= br_addr;
          end else begin
            if (rd_en) fa <= fa + 1'b1;
            if (last) state <= HALT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Program memory: contents deliberately survive reset
  always_ff @(posedge clock_in) begin
    if (bus.load_en_in && !run)
      mem[bus.load_addr_in] <= bus.load_data_in;
    if (rd_en)
      rd_data <= mem[fa[ADDR_W-1:0]];
  end

  // Read tracking, output register and skid register
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rd_pending <= 1'b0;
      rd_pc      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
    end else begin
      rd_pending <= rd_en;
      if (rd_en) rd_pc <= fa[ADDR_W-1:0];
      if (!run || br) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        rd_pending <= 1'b0;
      end else begin
        unique case (1'b1)
          (skid_valid && accept): begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_pc     <= skid_pc;
            skid_valid <= rd_pending;
            skid_data  <= rd_data;
            skid_pc    <= rd_pc;
          end
          (!skid_valid && (!out_valid || accept)): begin
            out_valid <= rd_pending;
            out_data  <= rd_data;
            out_pc    <= rd_pc;
          end
          (out_valid && !accept && rd_pending): begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data;
            skid_pc    <= rd_pc;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.current_instruction = out_valid ? out_data : 32'h0;
  assign bus.instr_valid_out     = out_valid;
  assign bus.pc_out              = out_pc;
  assign bus.busy_out            = run;
  assign bus.done_out            = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Branch checks run only when IFU_BRANCH_EN is defined.
module tb_instruction_fetch_unit;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch_unit #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock_in  (clk),
    .reset_n_in(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.load_en_in   = 1'b1;
    bus.load_addr_in = a;
    bus.load_data_in = d;
    step();
    bus.load_en_in   = 1'b0;
  endtask

  task automatic start(input logic [ADDR_W:0] len);
    bus.program_length_in = len;
    bus.start_in          = 1'b1;
    step();
    bus.start_in          = 1'b0;
  endtask

  task automatic see(input string tag, input logic [31:0] d,
                     input logic [ADDR_W-1:0] pc);
    check({tag, "_v"}, 32'(bus.instr_valid_out), 32'd1);
    check({tag, "_d"}, bus.current_instruction, d);
    check({tag, "_pc"}, 32'(bus.pc_out), 32'(pc));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !bus.done_out; i++) step();
    check(tag, 32'(bus.done_out), 32'd1);
  endtask

  int n;
  int bad;
  int last_pc;

  initial begin
    checks = 0;
    errors = 0;
    bus.load_en_in        = 1'b0;
    bus.load_addr_in      = '0;
    bus.load_data_in      = '0;
    bus.program_length_in = '0;
    bus.start_in          = 1'b0;
    bus.instr_ready_in    = 1'b1;
`ifdef IFU_BRANCH_EN
    bus.branch_en_in      = 1'b0;
    bus.branch_target_in  = '0;
`endif
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    step();
    step();
    check("rst_valid", 32'(bus.instr_valid_out), 32'd0);
    check("rst_instr", bus.current_instruction, 32'h0);
    check("rst_pc", 32'(bus.pc_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_done", 32'(bus.done_out), 32'd0);
    rst_n = 1'b1;
    step();

    load(10'd0, 32'h11);
    load(10'd1, 32'h22);
    load(10'd2, 32'h33);

    // zero length goes straight to HALT
    start(11'd0);
    check("len0_done", 32'(bus.done_out), 32'd1);
    check("len0_busy", 32'(bus.busy_out), 32'd0);
    check("len0_v0", 32'(bus.instr_valid_out), 32'd0);
    step();
    check("len0_v1", 32'(bus.instr_valid_out), 32'd0);

    // streaming with ready held high; a write during RUN is dropped
    start(11'd3);
    check("seq_busy", 32'(bus.busy_out), 32'd1);
    check("seq_lat0", 32'(bus.instr_valid_out), 32'd0);
    bus.load_en_in   = 1'b1;
    bus.load_addr_in = 10'd0;
    bus.load_data_in = 32'hdead_beef;
    step();
    bus.load_en_in   = 1'b0;
    check("seq_lat1", 32'(bus.instr_valid_out), 32'd0);
    check("seq_nop", bus.current_instruction, 32'h0);
    step();
    see("seq0", 32'h11, 10'd0);
    step();
    see("seq1", 32'h22, 10'd1);
    step();
    see("seq2", 32'h33, 10'd2);
    step();
    check("seq_end_v", 32'(bus.instr_valid_out), 32'd0);
    check("seq_end_d", bus.current_instruction, 32'h0);
    check("seq_done", 32'(bus.done_out), 32'd1);

    // stall on the second word
    start(11'd3);
    step();
    step();
    see("stl0", 32'h11, 10'd0);
    step();
    see("stl1", 32'h22, 10'd1);
    bus.instr_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      see("stl_hold", 32'h22, 10'd1);
    end
    bus.instr_ready_in = 1'b1;
    step();
    see("stl2", 32'h33, 10'd2);
    step();
    check("stl_end_v", 32'(bus.instr_valid_out), 32'd0);
    check("stl_done", 32'(bus.done_out), 32'd1);

    // reset mid-RUN, memory kept
    start(11'd3);
    step();
    step();
    see("mr0", 32'h11, 10'd0);
    step();
    see("mr1", 32'h22, 10'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_v", 32'(bus.instr_valid_out), 32'd0);
    check("mr_rst_d", bus.current_instruction, 32'h0);
    check("mr_rst_pc", 32'(bus.pc_out), 32'd0);
    check("mr_rst_busy", 32'(bus.busy_out), 32'd0);
    check("mr_rst_done", 32'(bus.done_out), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_idle_v", 32'(bus.instr_valid_out), 32'd0);
    end
    check("mr_idle_busy", 32'(bus.busy_out), 32'd0);
    check("mr_idle_done", 32'(bus.done_out), 32'd0);
    start(11'd3);
    step();
    step();
    see("mr_re0", 32'h11, 10'd0);
    wait_done("mr_drain");

`ifdef IFU_BRANCH_EN
    start(11'd3);
    step();
    step();
    see("br0", 32'h11, 10'd0);
    step();
    see("br1", 32'h22, 10'd1);
    step();
    see("br2", 32'h33, 10'd2);
    bus.branch_en_in     = 1'b1;
    bus.branch_target_in = 10'd0;
    step();
    bus.branch_en_in     = 1'b0;
    check("br_flush_v", 32'(bus.instr_valid_out), 32'd0);
    check("br_flush_d", bus.current_instruction, 32'h0);
    step();
    check("br_gap_v", 32'(bus.instr_valid_out), 32'd0);
    step();
    see("br_tgt0", 32'h11, 10'd0);
    step();
    see("br_tgt1", 32'h22, 10'd1);
    bus.branch_en_in     = 1'b1;
    bus.branch_target_in = 10'd7;
    step();
    bus.branch_en_in     = 1'b0;
    check("br_far_done", 32'(bus.done_out), 32'd1);
    check("br_far_v", 32'(bus.instr_valid_out), 32'd0);
`endif

    // length above DEPTH clips to DEPTH
    n       = 0;
    bad     = 0;
    last_pc = -1;
    start(11'(DEPTH + 5));
    for (int i = 0; i < 1500 && !bus.done_out; i++) begin
      step();
      if (bus.instr_valid_out) begin
        if (int'(bus.pc_out) != n) bad++;
        last_pc = int'(bus.pc_out);
        n++;
      end
    end
    check("clip_count", 32'(n), 32'(DEPTH));
    check("clip_last_pc", 32'(last_pc), 32'(DEPTH - 1));
    check("clip_order", 32'(bad), 32'd0);
    check("clip_done", 32'(bus.done_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 1024: instruction memory words.
REQ-002 Parameter ADDR_W, default 10: address width, equal to log2(DEPTH).
REQ-003 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 load_en_in  input  1  program-load write strobe.
REQ-006 load_addr_in  input  ADDR_W  program-load word address.
REQ-007 load_data_in  input  32  program-load instruction word.
REQ-008 program_length_in  input  ADDR_W+1  number of instructions to issue; sampled on start.
REQ-009 start_in  input  1  begin issuing from address 0.
REQ-010 instr_ready_in  input  1  downstream cpu accepts current_instruction this cycle.
REQ-011 current_instruction  output  32  instruction word to cpu.
REQ-012 instr_valid_out  output  1  current_instruction is valid.
REQ-013 pc_out  output  ADDR_W  address of the presented instruction.
REQ-014 busy_out  output  1  high in RUN.
REQ-015 done_out  output  1  high in HALT.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, HALT; reset enters IDLE.
- IDLE->RUN: start_in=1 with sampled length>0.
- IDLE->HALT: start_in=1 with length=0.
- RUN->HALT: last instruction accepted.
- HALT->RUN (or HALT): start_in=1, by the same length rule.
REQ-017 Sampled length above DEPTH SHALL be clipped to DEPTH.
REQ-018 The memory SHALL be written on load_en_in only in IDLE or HALT; writes in RUN are ignored.
REQ-019 The memory SHALL have synchronous read. The first instruction (address 0) SHALL be valid exactly 2 cycles after the start_in edge.
REQ-020 Transfer SHALL occur when instr_valid_out=1 and instr_ready_in=1. With ready held high, throughput SHALL be one instruction per cycle with no bubbles.
REQ-021 While instr_valid_out=1 and instr_ready_in=0, current_instruction and pc_out SHALL hold stable. No instruction is skipped or duplicated across stalls; a skid register is required.
REQ-022 When instr_valid_out=0, current_instruction SHALL be 32'h0 (NOP).
REQ-023 Instructions SHALL be issued in address order 0..length-1.
REQ-024 On acceptance of address length-1, instr_valid_out SHALL be 0 from the next cycle.
REQ-025 start_in SHALL be ignored in RUN.
REQ-026 Address arithmetic SHALL be ADDR_W+1 bits wide, so length=DEPTH issues address DEPTH-1 last without wrap.

Reset
REQ-027 On reset_n_in=0, outputs SHALL immediately become: instr_valid_out=0, current_instruction=0, pc_out=0, busy_out=0, done_out=0; FSM IDLE.
REQ-028 Reset SHALL NOT clear memory contents. Reset mid-RUN discards any in-flight fetch; after release no instruction is issued until start_in.

Configuration
REQ-029 Macro IFU_BRANCH_EN SHALL add inputs branch_en_in (1) and branch_target_in (ADDR_W).
- Effect, in RUN: branch_en_in=1 discards the presented instruction regardless of instr_ready_in. instr_valid_out SHALL be 0 the next cycle, and the target SHALL be valid 2 cycles after the branch edge, continuing sequentially.
- A target >= length SHALL enter HALT.
- Branch in IDLE/HALT SHALL be ignored.
- Without the macro, the ports SHALL not exist and issue is strictly sequential.

Verification
REQ-030 Load 0x11,0x22,0x33 at addresses 0..2, length=3, start, ready=1:
- output 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after start
- then valid=0, done_out=1.
REQ-031 Same program, ready low for 3 cycles while 0x22 is presented: 0x22 and pc_out=1 held; after ready rises, the sequence completes with no loss or duplicate.
REQ-032 length=0 with start: done_out=1 next cycle, valid never asserted.
REQ-033 Assert reset_n_in mid-RUN at pc=1, release, then start again: outputs zero asynchronously, and restart re-issues 0x11 from address 0 (memory retained).
REQ-034 length=DEPTH+5: exactly DEPTH instructions issued, the last with pc_out=DEPTH-1.
REQ-035 With IFU_BRANCH_EN: branch to 0 while 0x33 is presented. Check:
- 0x33 is discarded
- 0x11 is valid 2 cycles later
- a branch to target=7 with length=3 gives HALT.
